// File: rtl/aes_pkg.sv
// Shared types and GF(2^8) helpers for the AES MixColumns datapath.
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  col_t;
  typedef logic [7:0]   byte_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_t;

  // Low byte of the AES field polynomial x^8 + x^4 + x^3 + x + 1
  localparam byte_t GF_REDUCE = 8'h1B;

  // Multiply by x (i.e. by 02) in GF(2^8), reducing on overflow
  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_REDUCE : 8'h00);
  endfunction

endpackage

// File: rtl/aes_col_mix.sv
// Combinational single-column mixer: forward {02,03,01,01} or inverse
// {0e,0b,0d,09} circulant matrix over GF(2^8).
module aes_col_mix
  import aes_pkg::*;
(
  input  col_t col,
  input  logic decrypt,
  output col_t mixed
);

  byte_t b  [4];
  byte_t m2 [4];
  byte_t m3 [4];
  byte_t m4 [4];
  byte_t m8 [4];
  byte_t m9 [4];
  byte_t mb [4];
  byte_t md [4];
  byte_t me [4];
  byte_t r  [4];

  // Build every required multiple from the xtime chain, then combine per row
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      b[i]  = col[31-8*i -: 8];
      m2[i] = xtime(b[i]);
      m4[i] = xtime(m2[i]);
      m8[i] = xtime(m4[i]);
      m3[i] = m2[i] ^ b[i];
      m9[i] = m8[i] ^ b[i];
      mb[i] = m8[i] ^ m2[i] ^ b[i];
      md[i] = m8[i] ^ m4[i] ^ b[i];
      me[i] = m8[i] ^ m4[i] ^ m2[i];
    end
    if (!decrypt) begin
      r[0] = m2[0] ^ m3[1] ^ b[2]  ^ b[3];
      r[1] = b[0]  ^ m2[1] ^ m3[2] ^ b[3];
      r[2] = b[0]  ^ b[1]  ^ m2[2] ^ m3[3];
      r[3] = m3[0] ^ b[1]  ^ b[2]  ^ m2[3];
    end else begin
      r[0] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      r[1] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      r[2] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      r[3] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    end
    mixed = {r[0], r[1], r[2], r[3]};
  end

endmodule

// File: rtl/aes_mixcol_seq.sv
// Column-serial registered MixColumns stage. One 128-bit state is accepted,
// mixed one column per cycle, and held until the downstream handshake.
// Optional build macro AES_MIXCOL_ADDKEY_EN fuses AddRoundKey into the stage.
module aes_mixcol_seq
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_decrypt,
  input  logic         in_last,
`ifdef AES_MIXCOL_ADDKEY_EN
  input  logic [127:0] in_key,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  fsm_state_t state_q;
  logic [1:0] col_q;
  state_t     src_q;
  state_t     res_q;
  logic       decrypt_q;
  logic       last_q;
  logic       out_valid_q;
  logic       in_ready_q;
`ifdef AES_MIXCOL_ADDKEY_EN
  state_t     key_q;
`endif

  logic [1:0] col_idx;
  col_t       cur_col;
  col_t       mix_col;
  col_t       res_col;

  // Column 0 sits in the top word, so the bit slot counts down as col counts up
  assign col_idx = 2'd3 - col_q;
  assign cur_col = src_q[{col_idx, 5'd0} +: 32];

  aes_col_mix u_mix (
    .col     (cur_col),
    .decrypt (decrypt_q),
    .mixed   (mix_col)
  );

  // Final-round bypass and optional round-key fold for the current column
  always_comb begin
    res_col = last_q ? cur_col : mix_col;
`ifdef AES_MIXCOL_ADDKEY_EN
    res_col = res_col ^ key_q[{col_idx, 5'd0} +: 32];
`endif
  end

  // Handshake FSM, column counter and all datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      col_q       <= 2'd0;
      src_q       <= '0;
      res_q       <= '0;
      decrypt_q   <= 1'b0;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef AES_MIXCOL_ADDKEY_EN
      key_q       <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready_q) begin
            src_q      <= in_state;
            decrypt_q  <= in_decrypt;
            last_q     <= in_last;
`ifdef AES_MIXCOL_ADDKEY_EN
            key_q      <= in_key;
`endif
            col_q      <= 2'd0;
            in_ready_q <= 1'b0;
            state_q    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          res_q[{col_idx, 5'd0} +: 32] <= res_col;
          col_q <= col_q + 2'd1;
          if (col_q == 2'd3) begin
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          col_q       <= 2'd0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_state = res_q;

endmodule

// File: doc/aes_mixcol_seq.md
# aes_mixcol_seq

Column-serial, registered MixColumns stage for the AES round datapath. It accepts one 128-bit state after ShiftRows over a valid/ready handshake and processes one 32-bit column per cycle through a combinational column mixer, in forward or inverse mode. It reassembles the 128-bit result and presents it downstream over a second valid/ready handshake. It sits between the SubBytes/ShiftRows stage and the round-key stage and replaces a fully parallel four-column mixer where area matters.

## Interface
- No parameters. Data widths are fixed by AES.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  input state valid
- in_ready  out  1  stage can accept a state
- in_state  in  128  input state; column 0 = [127:96], column 3 = [31:0]; within a column, byte a = MSB
- in_decrypt  in  1  1 = InvMixColumns, 0 = MixColumns; sampled on accept
- in_last  in  1  1 = final round, mixing bypassed; sampled on accept
- in_key  in  128  round key; present only with AES_MIXCOL_ADDKEY_EN; sampled on accept
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_state  out  128  result state, same column ordering as in_state

## Operation
- State machine: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture in_state, in_decrypt and in_last (and in_key if enabled) into registers.
  - Clear col counter to 0 and go to BUSY.
- BUSY:
  - in_ready=0.
  - Each cycle, column[col] of the captured state goes through the mixer, and the result is written to column[col] of the result register.
  - The mixer is forward {02,03,01,01} circulant, or inverse {0e,0b,0d,09} circulant, over GF(2^8) with polynomial 0x11B.
  - If the captured last=1, the column passes through unchanged.
  - col increments by 1 each cycle. Writing col=3 goes to DONE. col is 2 bits; it never wraps while in BUSY.
- DONE:
  - out_valid=1. out_state holds the result and is stable.
  - out_valid&out_ready goes to IDLE.
  - No new input is accepted in DONE; in_ready=0. There is no overlap of consecutive states.
- in_valid while not IDLE is ignored. Upstream must hold it.
- in_decrypt, in_last and in_key changes after accept have no effect.
- Reset (asynchronous, any state, including mid-BUSY):
  - state=IDLE, col=0, out_valid=0, in_ready=1 from release, out_state=0.
  - The partial result is discarded.

## Timing
- Accept at clock edge E0. Columns 0..3 are written at edges E1..E4. out_valid rises after E4.
- Latency is 4 cycles from the accept edge to out_valid. It is identical for forward, inverse and bypass.
- Minimum initiation interval is 6 cycles: accept, 4 BUSY, DONE with out_ready=1. The next accept is possible at the edge after the DONE handshake.
- out_ready held low: DONE persists indefinitely and out_state is unchanged.
- in_ready is a registered state decode, not combinational on out_ready.

## Configuration
- AES_MIXCOL_ADDKEY_EN defined:
  - Port in_key exists and a 128-bit key register is added.
  - Each result column = mixer output XOR key column[col]. For last=1 it is column XOR key column.
  - This fuses AddRoundKey into the stage.
  - Decrypt integrators use the equivalent inverse cipher, with InvMixColumns-transformed keys.
- Undefined: no in_key port, no key register, result = mixer output only. Timing is identical in both builds.

## Structure
- Shared package aes_pkg holds:
  - state/column/byte typedefs (128/32/8);
  - the FSM state enum;
  - the GF reduction constant 8'h1B;
  - an xtime function.
- One sub-module, aes_col_mix: combinational, 32-bit column in, decrypt select in, 32-bit mixed column out.
- All registers, the FSM and the col counter live in aes_mixcol_seq.

## Test plan
- Forward, last=0: column 0 = db135345 (other columns f20a225c, 01010101, c6c6c6c6) -> out_state = 8e4da1bc_9fdc589d_01010101_c6c6c6c6, out_valid exactly 4 cycles after accept.
- Inverse, last=0: input 8e4da1bc_9fdc589d_01010101_d5d5d7d6 -> db135345_f20a225c_01010101_d4d4d4d5.
- Bypass: last=1, input 00112233_44556677_8899aabb_ccddeeff -> identical output, same 4-cycle latency.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_valid and out_state stable, in_ready=0 throughout, and an in_valid pulse during this time is not accepted. Then out_ready=1 -> IDLE next cycle and the next state is accepted.
- Reset mid-BUSY: assert rst after column 1 is written -> out_valid=0, out_state=0, in_ready=1 immediately. A fresh state then completes correctly.
- AES_MIXCOL_ADDKEY_EN build: forward input column 2d26314c (rest 0), key all ff -> column 0 = b28142 07, i.e. 4d7ebdf8^ffffffff = b2814207, other columns = ffffffff.
